// File: rtl/bram_sum_top.sv
// Single-port 8x8 write-first block RAM with a registered pairwise-sum output.
// Optional build macro MEM_CLEAR_EN: a reset edge also clears every memory word to 0.
module bram_sum_top #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W:0]   sum
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;
    logic [DATA_W:0]   sum_q;
    logic [DATA_W:0]   sum_d;
    logic [DATA_W-1:0] word_s;

    // Port word: write data on a write (write-first), stored word on a read.
    always_comb begin
        word_s = mem_q[addr];
        if (wea) begin
            word_s = data_in;
        end else begin
            word_s = mem_q[addr];
        end
    end

    // Next output state; sum is one bit wider so 255 + 255 never truncates.
    always_comb begin
        data_out_d = word_s;
        sum_d      = {1'b0, word_s} + {1'b0, data_out_q};
    end

    // Storage array; reset blocks writes and optionally clears the contents.
    always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_EN
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wea) begin
            mem_q[addr] <= data_in;
        end
`else
        if (!rst && wea) begin
            mem_q[addr] <= data_in;
        end
`endif
    end

    // Registered port data and pairwise sum; reset restarts the sum with previous = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= {DATA_W{1'b0}};
            sum_q      <= {(DATA_W + 1){1'b0}};
        end else begin
            data_out_q <= data_out_d;
            sum_q      <= sum_d;
        end
    end

    assign data_out = data_out_q;
    assign sum      = sum_q;

endmodule

// File: tb/tb_bram_sum_top.sv
// Self-checking bench for bram_sum_top: directed vector table plus a random
// phase against a behavioural model, both checked through an expectation queue.
module tb_bram_sum_top;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NVEC   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              wea;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W:0]   sum;

    always #5 clk = ~clk;

    bram_sum_top #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wea      (wea),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .sum      (sum)
    );

    typedef struct {
        logic              r;
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_dout;
        logic [DATA_W:0]   exp_sum;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] dout;
        logic [DATA_W:0]   sum;
        string             name;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[NVEC];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [DATA_W-1:0] mem_m [2 ** ADDR_W];
    logic [DATA_W-1:0] prev_m;

    task automatic check_one();
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: output cycle with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            if (data_out !== e.dout || sum !== e.sum) begin
                n_bad++;
                $display("FAIL %s: data_out=%0d sum=%0d, required data_out=%0d sum=%0d",
                         e.name, data_out, sum, e.dout, e.sum);
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] ed,
                        input logic [DATA_W:0] es, input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        wea     = w;
        addr    = a;
        data_in = d;
        e.dout  = ed;
        e.sum   = es;
        e.name  = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    task automatic model_step(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input string nm);
        logic [DATA_W-1:0] word;
        logic [DATA_W:0]   es;
        if (r) begin
`ifdef MEM_CLEAR_EN
            for (int i = 0; i < 2 ** ADDR_W; i++) mem_m[i] = 8'd0;
`endif
            prev_m = 8'd0;
            step(r, w, a, d, 8'd0, 9'd0, nm);
        end else begin
            word = w ? d : mem_m[a];
            if (w) mem_m[a] = d;
            es = {1'b0, word} + {1'b0, prev_m};
            prev_m = word;
            step(r, w, a, d, word, es, nm);
        end
    endtask

    initial begin
        rst     = 1'b0;
        wea     = 1'b0;
        addr    = 3'd0;
        data_in = 8'd0;

        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'd0,   9'd0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 8'd7,  8'd7,   9'd7};
        tbl[2]  = '{1'b0, 1'b1, 3'd1, 8'd3,  8'd3,   9'd10};
        tbl[3]  = '{1'b0, 1'b1, 3'd2, 8'd1,  8'd1,   9'd4};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 8'd7,   9'd8};
        tbl[5]  = '{1'b0, 1'b0, 3'd1, 8'h00, 8'd3,   9'd10};
        tbl[6]  = '{1'b0, 1'b0, 3'd2, 8'h00, 8'd1,   9'd4};
        tbl[7]  = '{1'b0, 1'b1, 3'd5, 8'd255, 8'd255, 9'd256};
        tbl[8]  = '{1'b0, 1'b0, 3'd5, 8'h00, 8'd255, 9'h1FE};
        tbl[9]  = '{1'b0, 1'b1, 3'd7, 8'h12, 8'h12,  9'd273};
        tbl[10] = '{1'b0, 1'b1, 3'd7, 8'h34, 8'h34,  9'h046};
        tbl[11] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'h34,  9'h068};
        // Reset with a write request: the write must be ignored.
        tbl[12] = '{1'b1, 1'b1, 3'd1, 8'hAA, 8'd0,   9'd0};
`ifdef MEM_CLEAR_EN
        tbl[13] = '{1'b0, 1'b0, 3'd1, 8'h00, 8'd0,   9'd0};
        tbl[14] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'd0,   9'd0};
`else
        tbl[13] = '{1'b0, 1'b0, 3'd1, 8'h00, 8'd3,   9'd3};
        tbl[14] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'h34,  9'h037};
`endif

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d,
                 tbl[i].exp_dout, tbl[i].exp_sum, $sformatf("vec%0d", i));
        end

        // Random phase: reset, fill every word so the model is fully known, then mix.
        for (int i = 0; i < 2 ** ADDR_W; i++) mem_m[i] = 8'd0;
        prev_m = 8'd0;
        model_step(1'b1, 1'b0, 3'd0, 8'd0, "rnd_reset");
        for (int i = 0; i < 2 ** ADDR_W; i++) begin
            model_step(1'b0, 1'b1, 3'(i), 8'($urandom), $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 200; i++) begin
            model_step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 8'($urandom), $sformatf("rnd%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_sum_top.md
Name: bram_sum_top

Overview:
- Single-port 8x8 block RAM with a synchronous, write-first port and a registered pairwise-sum output.
- `data_out` is the word written or read this cycle.
- `sum` is the 9-bit sum of the two most recent port words: the current and the previous `data_out`.
- Used as a small scratchpad plus running pairwise adder for simple data-path experiments and BRAM inference checks.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 3, address width in bits; depth = 2**ADDR_W = 8 words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wea  input  1  write enable; 1 = write `data_in` to `mem[addr]`, 0 = read `mem[addr]`.
- addr  input  ADDR_W (3)  word address, 0..7.
- data_in  input  DATA_W (8)  write data.
- data_out  output  DATA_W (8)  registered port data.
- sum  output  DATA_W+1 (9)  registered sum of the current and previous port words.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - Reset is sampled on the rising edge of `clk` and has priority over `wea`.
- Reset values:
  - `data_out` = 0, `sum` = 0.
  - Memory contents are not cleared by reset unless MEM_CLEAR_EN is defined.
  - No write occurs in a reset cycle, even if `wea` = 1.
- Storage: `mem[0..7]`, each DATA_W bits, with undefined contents at power-up.
- Port word: `word = wea ? data_in : mem[addr]`.
  - Write-first: on a write, `data_out` shows the new data.
- Each rising edge with `rst` = 0:
  - if `wea`: `mem[addr]` <= `data_in`.
  - `data_out` <= `word`.
  - `sum` <= zero-extended `word` + zero-extended old `data_out` (value before this edge).
- Latency:
  - `data_out` is valid one cycle after `addr`/`wea`/`data_in` are presented.
  - `sum` updates on the same edge as `data_out`.
- Width rule: `sum` is DATA_W+1 bits, so it never overflows; maximum value 255 + 255 = 510.
- After reset, the first port word gives `sum` = word + 0.
- Addressing: all 8 addresses are valid; there is no out-of-range case and no wrap logic.
- Back-to-back writes to the same address: the last write wins; each write's data appears on `data_out` in its own cycle.
- Read immediately after a write to the same address returns the written value; no stale read.
- Unknown `addr`/`data_in` while `wea` = 0:
  - memory is unchanged;
  - `data_out` and `sum` may go unknown, with no other side effect.
- Reset mid-stream:
  - `data_out` and `sum` return to 0 on the reset edge;
  - memory keeps its contents (unless MEM_CLEAR_EN is defined).
- Pipeline after reset: the next access restarts the sum with previous = 0.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- Defined: a reset edge also clears all 8 memory words to 0 in the same cycle, so a read after reset returns 0.
- Not defined: reset affects only `data_out` and `sum`; memory is preserved across reset.

Test Plan:
- Basic write sequence:
  - Stimulus: `rst` = 1 for one cycle, then `wea` = 1 with (addr 0, 7), (1, 3), (2, 1) on consecutive cycles.
  - Required: `data_out` = 7, 3, 1; `sum` = 7, 10, 4.
- Read-back:
  - Stimulus: after the writes, `wea` = 0, addr = 0, 1, 2.
  - Required: `data_out` = 7, 3, 1; `sum` = 1+7 = 8, then 10, then 4.
- Overflow width:
  - Stimulus: write 255 to addr 5, then read addr 5.
  - Required: `data_out` = 255; `sum` = 510 (9'h1FE), with no truncation.
- Write-first and overwrite:
  - Stimulus: write 0x12 then 0x34 to addr 7, then read addr 7.
  - Required: `data_out` = 0x12, 0x34, 0x34; `sum` ends at 0x68.
- Reset mid-stream, macro undefined:
  - Stimulus: assert `rst` after the writes, then read addr 1.
  - Required: `data_out` = 0 and `sum` = 0 on the reset edge; the read then gives `data_out` = 3, `sum` = 3.
- Reset with MEM_CLEAR_EN defined:
  - Stimulus: same sequence as the previous scenario.
  - Required: the read of addr 1 returns 0 and `sum` = 0.
